// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the XB pipeline stage and csr_trap_unit.
//   master : XB stage; drives the instruction slot and CSR operation fields,
//            receives registered read data and the illegal-CSR flag.
//   slave  : csr_trap_unit.
// Signals:
//   XB_bubble                               XB slot holds no instruction
//   csr_read/csr_write/csr_set/csr_clear    CSR operation of the XB instruction
//   csr_imm                                 operand is uimm, else d_rs1
//   csr_addr[11:0]                          CSR address
//   a_rd[4:0]                               destination register
//   uimm[4:0]                               rs1/uimm field
//   d_rs1[31:0]                             rs1 value
//   data_out[31:0]                          CSR read data, one cycle after access
//   csr_illegal                             unimplemented CSR accessed (combinational)
interface csr_trap_unit_if;
  logic        XB_bubble;
  logic        csr_read;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clear;
  logic        csr_imm;
  logic [11:0] csr_addr;
  logic [4:0]  a_rd;
  logic [4:0]  uimm;
  logic [31:0] d_rs1;
  logic [31:0] data_out;
  logic        csr_illegal;

  modport master (
    output XB_bubble, csr_read, csr_write, csr_set, csr_clear, csr_imm,
           csr_addr, a_rd, uimm, d_rs1,
    input  data_out, csr_illegal
  );

  modport slave (
    input  XB_bubble, csr_read, csr_write, csr_set, csr_clear, csr_imm,
           csr_addr, a_rd, uimm, d_rs1,
    output data_out, csr_illegal
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR and trap unit beside the XB stage.
// Holds the M-mode trap CSRs and 64-bit cycle/instret counters, captures
// NUM_IRQ local interrupt lines (level or rising-edge per line) plus the
// machine timer, and arbitrates interrupts against synchronous exceptions.
// Ports:
//   clk, resetb        clock, asynchronous active-low reset
//   xb                 CSR access bus (slave side), see csr_trap_unit_if
//   XB_pc[29:0]        PC[31:2] of the XB instruction
//   exc_valid/cause/tval  upstream synchronous exception
//   mret               XB instruction is mret
//   irq_mtimer         machine timer compare level
//   irq_ext            local interrupt lines, line i -> cause/mie/mip bit 16+i
//   trap_take, trap_pc trap this cycle and its handler target (combinational)
//   mret_pc            {mepc[31:2],2'b00}
//   irq_pending        |(mie & mip), independent of mstatus.MIE
module csr_trap_unit #(
  parameter int unsigned  NUM_IRQ       = 4,
  parameter logic [15:0]  IRQ_EDGE_MASK = '0,
  parameter logic [31:0]  RESET_MTVEC   = 32'h4,
  parameter bit           VECTORED_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               resetb,
  csr_trap_unit_if.slave     xb,
  input  logic [29:0]        XB_pc,
  input  logic               exc_valid,
  input  logic [3:0]         exc_cause,
  input  logic [31:0]        exc_tval,
  input  logic               mret,
  input  logic               irq_mtimer,
  input  logic [NUM_IRQ-1:0] irq_ext,
  output logic               trap_take,
  output logic [31:0]        trap_pc,
  output logic [31:0]        mret_pc,
  output logic               irq_pending
);

  localparam logic [NUM_IRQ-1:0] EDGE = IRQ_EDGE_MASK[NUM_IRQ-1:0];

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;

  // architectural state
  logic               mst_mie, mst_mpie;
  logic               mie_mtie;
  logic [NUM_IRQ-1:0] mie_ext;
  logic [NUM_IRQ-1:0] irq_pend, irq_hist;
  logic [29:0]        mtvec_base;
  logic               mtvec_mode;
  logic [31:0]        mscratch;
  logic [29:0]        mepc;
  logic [31:0]        mcause, mtval;
  logic [63:0]        mcycle, minstret;

  // datapath
  logic               v, any_op, csr_hit, wr_en, retire, do_mret;
  logic [31:0]        operand, rdata, wdata;
  logic [31:0]        mip_word, mie_word, mstatus_word;
  logic [NUM_IRQ-1:0] mip_ext, en_ext, rise, mip_clr;
  logic               mti, int_req;
  logic [4:0]         int_cause;
  logic [31:0]        trap_cause;
  logic [63:0]        mcycle_nx, minstret_nx;

  assign v       = ~xb.XB_bubble;
  assign any_op  = xb.csr_read | xb.csr_write | xb.csr_set | xb.csr_clear;
  assign operand = xb.csr_imm ? {27'b0, xb.uimm} : xb.d_rs1;

  // Edge lines report the sticky pending bit, level lines the live input.
  assign mip_ext = (irq_pend & EDGE) | (irq_ext & ~EDGE);
  assign rise    = irq_ext & ~irq_hist;

  always_comb begin
    mip_word    = '0;
    mie_word    = '0;
    mip_word[7] = irq_mtimer;
    mie_word[7] = mie_mtie;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      mip_word[16+i] = mip_ext[i];
      mie_word[16+i] = mie_ext[i];
    end
  end

  assign mstatus_word = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

  always_comb begin
    rdata   = '0;
    csr_hit = 1'b0;
    case (xb.csr_addr)
      12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_hit = 1'b1;
      A_MISA:      begin csr_hit = 1'b1; rdata = 32'h4000_0100;               end
      A_MSTATUS:   begin csr_hit = 1'b1; rdata = mstatus_word;                end
      A_MIE:       begin csr_hit = 1'b1; rdata = mie_word;                    end
      A_MIP:       begin csr_hit = 1'b1; rdata = mip_word;                    end
      A_MTVEC:     begin csr_hit = 1'b1; rdata = {mtvec_base, 1'b0, mtvec_mode}; end
      A_MSCRATCH:  begin csr_hit = 1'b1; rdata = mscratch;                    end
      A_MEPC:      begin csr_hit = 1'b1; rdata = {mepc, 2'b00};               end
      A_MCAUSE:    begin csr_hit = 1'b1; rdata = mcause;                      end
      A_MTVAL:     begin csr_hit = 1'b1; rdata = mtval;                       end
      A_MCYCLE:    begin csr_hit = 1'b1; rdata = mcycle[31:0];                end
      A_MCYCLEH:   begin csr_hit = 1'b1; rdata = mcycle[63:32];               end
      A_MINSTRET:  begin csr_hit = 1'b1; rdata = minstret[31:0];              end
      A_MINSTRETH: begin csr_hit = 1'b1; rdata = minstret[63:32];             end
      default: begin
        // unimplemented hpm counters/events and mcountinhibit read as zero
        if (xb.csr_addr[11:4] inside {8'hB0, 8'hB1, 8'hB8, 8'hB9, 8'h32, 8'h33})
          csr_hit = 1'b1;
      end
    endcase
  end

  assign xb.csr_illegal = v & any_op & ~csr_hit;

  // interrupt arbitration: MTI first, then lowest-numbered local line
  assign mti         = mie_mtie & irq_mtimer;
  assign en_ext      = mie_ext & mip_ext;
  assign irq_pending = mti | (|en_ext);
  assign int_req     = mst_mie & irq_pending;

  always_comb begin
    logic found;
    int_cause = 5'd7;
    found     = mti;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!found && en_ext[i]) begin
        int_cause = 5'(16 + i);
        found     = 1'b1;
      end
    end
  end

  assign trap_take  = v & (int_req | exc_valid | xb.csr_illegal);
  assign trap_cause = int_req   ? {1'b1, 26'b0, int_cause} :
                      exc_valid ? {28'b0, exc_cause}       : 32'd2;
  assign trap_pc    = (mtvec_mode && int_req) ?
                      {mtvec_base, 2'b00} + {25'b0, int_cause, 2'b00} :
                      {mtvec_base, 2'b00};
  assign mret_pc    = {mepc, 2'b00};

  // a trapping instruction neither writes CSRs, retires, nor returns
  assign wr_en   = v & ~trap_take &
                   (xb.csr_write | ((xb.csr_set | xb.csr_clear) & (xb.uimm != '0)));
  assign wdata   = xb.csr_write ? operand :
                   xb.csr_set   ? (rdata | operand) : (rdata & ~operand);
  assign retire  = v & ~trap_take;
  assign do_mret = v & mret & ~trap_take;

  // write/clear of mip can only lower edge-pending bits; a same-cycle rising
  // edge wins because rise is OR-ed in after the clear
  assign mip_clr = (wr_en && xb.csr_addr == A_MIP) ? ~wdata[16 +: NUM_IRQ] : '0;

  assign mcycle_nx   = mcycle + 64'd1;
  assign minstret_nx = minstret + 64'd1;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mst_mie     <= 1'b0;
      mst_mpie    <= 1'b0;
      mie_mtie    <= 1'b0;
      mie_ext     <= '0;
      irq_pend    <= '0;
      irq_hist    <= '0;
      mtvec_base  <= RESET_MTVEC[31:2];
      mtvec_mode  <= 1'b0;
      mscratch    <= '0;
      mepc        <= '0;
      mcause      <= '0;
      mtval       <= '0;
      mcycle      <= '0;
      minstret    <= '0;
      xb.data_out <= '0;
    end else begin
      irq_hist <= irq_ext;
      irq_pend <= ((irq_pend & ~mip_clr) | rise) & EDGE;

      if (v && xb.csr_read && xb.a_rd != '0)
        xb.data_out <= rdata;

      if (trap_take) begin
        mepc     <= XB_pc;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
        mcause   <= trap_cause;
        mtval    <= (int_req || !exc_valid) ? '0 : exc_tval;
      end else if (do_mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_en) begin
        case (xb.csr_addr)
          A_MSTATUS: begin
            mst_mie  <= wdata[3];
            mst_mpie <= wdata[7];
          end
          A_MIE: begin
            mie_mtie <= wdata[7];
            mie_ext  <= wdata[16 +: NUM_IRQ];
          end
          A_MTVEC: begin
            mtvec_base <= wdata[31:2];
            if (wdata[1:0] == 2'b00)
              mtvec_mode <= 1'b0;
            else if (wdata[1:0] == 2'b01)
              mtvec_mode <= VECTORED_EN;
          end
          A_MSCRATCH: mscratch <= wdata;
          A_MEPC:     mepc     <= wdata[31:2];
          A_MCAUSE:   mcause   <= wdata;
          A_MTVAL:    mtval    <= wdata;
          default: ;
        endcase
      end

      if (wr_en && xb.csr_addr == A_MCYCLE)  mcycle[31:0]  <= wdata;
      else                                   mcycle[31:0]  <= mcycle_nx[31:0];
      if (wr_en && xb.csr_addr == A_MCYCLEH) mcycle[63:32] <= wdata;
      else                                   mcycle[63:32] <= mcycle_nx[63:32];

      if (wr_en && xb.csr_addr == A_MINSTRET)       minstret[31:0]  <= wdata;
      else if (retire)                              minstret[31:0]  <= minstret_nx[31:0];
      if (wr_en && xb.csr_addr == A_MINSTRETH)      minstret[63:32] <= wdata;
      else if (retire)                              minstret[63:32] <= minstret_nx[63:32];
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: line 0 is edge-latched, other lines level.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled on the falling edge, registered outputs 1 unit after the rising edge.
module tb_csr_trap_unit;

  localparam logic [3:0] OP_RS = 4'b1010;  // {read, write, set, clear}
  localparam logic [3:0] OP_W  = 4'b0100;
  localparam logic [3:0] OP_S  = 4'b0010;
  localparam logic [3:0] OP_C  = 4'b0001;

  logic        clk;
  logic        resetb;
  logic [29:0] XB_pc;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic        mret;
  logic        irq_mtimer;
  logic [3:0]  irq_ext;
  logic        trap_take;
  logic [31:0] trap_pc;
  logic [31:0] mret_pc;
  logic        irq_pending;

  int checks   = 0;
  int failures = 0;

  csr_trap_unit_if bus ();

  csr_trap_unit #(
    .NUM_IRQ       (4),
    .IRQ_EDGE_MASK (16'h0001),
    .RESET_MTVEC   (32'h4),
    .VECTORED_EN   (1'b1)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .xb          (bus),
    .XB_pc       (XB_pc),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .exc_tval    (exc_tval),
    .mret        (mret),
    .irq_mtimer  (irq_mtimer),
    .irq_ext     (irq_ext),
    .trap_take   (trap_take),
    .trap_pc     (trap_pc),
    .mret_pc     (mret_pc),
    .irq_pending (irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    bus.XB_bubble = 1'b1;
    bus.csr_read  = 1'b0;
    bus.csr_write = 1'b0;
    bus.csr_set   = 1'b0;
    bus.csr_clear = 1'b0;
    bus.csr_imm   = 1'b0;
    bus.csr_addr  = '0;
    bus.a_rd      = '0;
    bus.uimm      = '0;
    bus.d_rs1     = '0;
    exc_valid     = 1'b0;
    exc_cause     = '0;
    exc_tval      = '0;
    mret          = 1'b0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [11:0] addr, input logic [4:0] rd,
                          input logic [4:0] u, input logic [31:0] rs1, input logic imm);
    bus.XB_bubble = 1'b0;
    {bus.csr_read, bus.csr_write, bus.csr_set, bus.csr_clear} = op;
    bus.csr_addr  = addr;
    bus.a_rd      = rd;
    bus.uimm      = u;
    bus.d_rs1     = rs1;
    bus.csr_imm   = imm;
  endtask

  task automatic csr_op(input logic [3:0] op, input logic [11:0] addr, input logic [4:0] rd,
                        input logic [4:0] u, input logic [31:0] rs1, input logic imm);
    drive_op(op, addr, rd, u, rs1, imm);
    tick();
    clear_ops();
  endtask

  task automatic wr_csr(input logic [11:0] addr, input logic [31:0] data);
    csr_op(OP_W, addr, 5'd0, 5'd1, data, 1'b0);
  endtask

  // csrrs x1, addr, x0
  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_op(OP_RS, addr, 5'd1, 5'd0, 32'd0, 1'b0);
    check(tag, bus.data_out, exp);
  endtask

  initial begin
    resetb     = 1'b0;
    XB_pc      = '0;
    irq_mtimer = 1'b0;
    irq_ext    = '0;
    clear_ops();
    repeat (2) tick();
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_mret_pc", mret_pc, 32'h0);
    check("rst_irq_pending", {31'b0, irq_pending}, 32'h0);
    @(negedge clk);
    resetb = 1'b1;
    tick();

    // reset values and read-only CSRs
    rd_chk("mtvec_rst", 12'h305, 32'h4);
    rd_chk("mcause_rst", 12'h342, 32'h0);
    rd_chk("misa", 12'h301, 32'h4000_0100);
    rd_chk("mstatus_rst", 12'h300, 32'h0000_1800);
    rd_chk("mhartid", 12'hF14, 32'h0);

    // read/write semantics
    wr_csr(12'h340, 32'hDEAD_BEEF);
    rd_chk("mscratch", 12'h340, 32'hDEAD_BEEF);
    csr_op(OP_RS, 12'h301, 5'd0, 5'd0, 32'd0, 1'b0);
    check("rd_x0_hold", bus.data_out, 32'hDEAD_BEEF);
    csr_op(OP_S, 12'h340, 5'd0, 5'd0, 32'h0000_00FF, 1'b0);
    rd_chk("set_uimm0", 12'h340, 32'hDEAD_BEEF);
    csr_op(OP_C, 12'h340, 5'd0, 5'h0F, 32'd0, 1'b1);
    rd_chk("clr_imm", 12'h340, 32'hDEAD_BEE0);
    drive_op(OP_W, 12'h340, 5'd0, 5'd1, 32'h0, 1'b0);
    bus.XB_bubble = 1'b1;
    tick();
    clear_ops();
    rd_chk("bubble_wr", 12'h340, 32'hDEAD_BEE0);

    // mtvec MODE handling
    wr_csr(12'h305, 32'h101);
    rd_chk("mtvec_vec", 12'h305, 32'h101);
    wr_csr(12'h305, 32'h202);
    rd_chk("mtvec_mode2", 12'h305, 32'h201);
    wr_csr(12'h305, 32'h101);

    // mcycle write override and carry into the high half
    wr_csr(12'hB00, 32'hFFFF_FFFF);
    rd_chk("mcycle_lo", 12'hB00, 32'hFFFF_FFFF);
    rd_chk("mcycle_hi", 12'hB80, 32'h1);

    // vectored interrupt on edge line 0
    wr_csr(12'h304, 32'h0001_0000);
    csr_op(OP_S, 12'h300, 5'd0, 5'd8, 32'd0, 1'b1);
    irq_ext = 4'b0001;
    tick();
    check("irq_pend_edge", {31'b0, irq_pending}, 32'h1);
    check("bubble_no_trap", {31'b0, trap_take}, 32'h0);
    bus.XB_bubble = 1'b0;
    XB_pc = 30'h80;
    @(negedge clk);
    check("int_take", {31'b0, trap_take}, 32'h1);
    check("int_trap_pc", trap_pc, 32'h140);
    tick();
    clear_ops();
    rd_chk("int_mcause", 12'h342, 32'h8000_0010);
    rd_chk("int_mepc", 12'h341, 32'h200);
    rd_chk("int_mstatus", 12'h300, 32'h0000_1880);
    check("int_mret_pc", mret_pc, 32'h200);
    irq_ext = 4'b0000;
    csr_op(OP_C, 12'h344, 5'd0, 5'd1, 32'h0001_0000, 1'b0);
    rd_chk("mip_clr", 12'h344, 32'h0);

    // edge capture with mie off
    wr_csr(12'h304, 32'h0);
    irq_ext = 4'b0001;
    tick();
    irq_ext = 4'b0000;
    tick();
    rd_chk("mip_sticky", 12'h344, 32'h0001_0000);
    irq_ext = 4'b0001;
    csr_op(OP_C, 12'h344, 5'd0, 5'd1, 32'h0001_0000, 1'b0);
    irq_ext = 4'b0000;
    rd_chk("mip_setclr", 12'h344, 32'h0001_0000);
    csr_op(OP_C, 12'h344, 5'd0, 5'd1, 32'h0001_0000, 1'b0);
    rd_chk("mip_clr_noedge", 12'h344, 32'h0);
    irq_ext = 4'b0010;
    rd_chk("mip_level_hi", 12'h344, 32'h0002_0000);
    irq_ext = 4'b0000;
    rd_chk("mip_level_lo", 12'h344, 32'h0);

    // MIE gating, then timer beats line 1 and the exception
    wr_csr(12'h343, 32'h55);
    wr_csr(12'h304, 32'h0002_0080);
    irq_mtimer = 1'b1;
    bus.XB_bubble = 1'b0;
    XB_pc = 30'h10;
    @(negedge clk);
    check("gate_pending", {31'b0, irq_pending}, 32'h1);
    check("gate_no_trap", {31'b0, trap_take}, 32'h0);
    tick();
    clear_ops();
    csr_op(OP_S, 12'h300, 5'd0, 5'd8, 32'd0, 1'b1);
    irq_ext = 4'b0010;
    exc_valid = 1'b1;
    exc_cause = 4'd4;
    exc_tval = 32'h33;
    bus.XB_bubble = 1'b0;
    XB_pc = 30'h90;
    @(negedge clk);
    check("prio_take", {31'b0, trap_take}, 32'h1);
    check("prio_trap_pc", trap_pc, 32'h11C);
    tick();
    clear_ops();
    irq_mtimer = 1'b0;
    irq_ext = 4'b0000;
    rd_chk("prio_mcause", 12'h342, 32'h8000_0007);
    rd_chk("prio_mtval", 12'h343, 32'h0);
    rd_chk("prio_mepc", 12'h341, 32'h240);

    // synchronous exception, not vectored
    exc_valid = 1'b1;
    exc_cause = 4'd4;
    exc_tval = 32'h33;
    bus.XB_bubble = 1'b0;
    XB_pc = 30'hA0;
    @(negedge clk);
    check("exc_take", {31'b0, trap_take}, 32'h1);
    check("exc_trap_pc", trap_pc, 32'h100);
    tick();
    clear_ops();
    rd_chk("exc_mcause", 12'h342, 32'h4);
    rd_chk("exc_mtval", 12'h343, 32'h33);
    rd_chk("exc_mepc", 12'h341, 32'h280);

    // illegal CSR; trapping instruction does not retire
    wr_csr(12'hB02, 32'd100);
    drive_op(OP_RS, 12'h7C0, 5'd1, 5'd0, 32'd0, 1'b0);
    XB_pc = 30'hB0;
    @(negedge clk);
    check("ill_flag", {31'b0, bus.csr_illegal}, 32'h1);
    check("ill_take", {31'b0, trap_take}, 32'h1);
    tick();
    clear_ops();
    rd_chk("ill_minstret", 12'hB02, 32'd100);
    rd_chk("ill_mcause", 12'h342, 32'h2);
    rd_chk("ill_mtval", 12'h343, 32'h0);
    drive_op(OP_RS, 12'h7C0, 5'd1, 5'd0, 32'd0, 1'b0);
    bus.XB_bubble = 1'b1;
    @(negedge clk);
    check("ill_bubble_flag", {31'b0, bus.csr_illegal}, 32'h0);
    check("ill_bubble_take", {31'b0, trap_take}, 32'h0);
    tick();
    clear_ops();

    // mret
    wr_csr(12'h300, 32'h80);
    bus.XB_bubble = 1'b0;
    mret = 1'b1;
    @(negedge clk);
    check("mret_no_trap", {31'b0, trap_take}, 32'h0);
    check("mret_pc", mret_pc, 32'h2C0);
    tick();
    clear_ops();
    rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

    // MIE write applies next cycle; then mret loses to the interrupt
    wr_csr(12'h300, 32'h80);
    irq_mtimer = 1'b1;
    drive_op(OP_W, 12'h300, 5'd0, 5'd1, 32'h08, 1'b0);
    @(negedge clk);
    check("mie_wr_delay", {31'b0, trap_take}, 32'h0);
    tick();
    clear_ops();
    bus.XB_bubble = 1'b0;
    mret = 1'b1;
    XB_pc = 30'hC0;
    @(negedge clk);
    check("mret_irq_take", {31'b0, trap_take}, 32'h1);
    check("mret_irq_pc", trap_pc, 32'h11C);
    tick();
    clear_ops();
    irq_mtimer = 1'b0;
    rd_chk("mret_irq_mcause", 12'h342, 32'h8000_0007);
    rd_chk("mret_irq_mepc", 12'h341, 32'h300);
    rd_chk("mret_irq_mstatus", 12'h300, 32'h0000_1880);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
